matmul_c_collector: RTL and testbench
=====================================

# matmul_c_collector

Result-side sink for `matmul_16_16_systolic`. It captures the C-matrix rows the array emits on `c_data_available`/`c_addr`/`c_data_out`, checks them against the expected address sequence, and buffers up to 16 rows. It then drains the rows to a downstream consumer over a valid/ready stream, and pulses a completion flag when the drain finishes. It sits between the systolic array's C write port and the result writeback/DMA logic.

## Interface
- `DWIDTH`, 8, element width in bits
- `MAT_MUL_SIZE`, 16, rows/columns of the array
- `AWIDTH`, 10, C address width
- `ADDR_STRIDE_WIDTH`, 16, stride width
- `clk`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start_collect`  in  1  arm pulse; honoured only in IDLE
- `address_mat_c`  in  AWIDTH  base address of the first C row
- `address_stride_c`  in  ADDR_STRIDE_WIDTH  address increment per row
- `final_mat_mul_size`  in  8  rows to collect
- `c_data_available`  in  1  array row strobe
- `c_addr`  in  AWIDTH  array row address
- `c_data_out`  in  MAT_MUL_SIZE*DWIDTH  array row data, element 0 in the LSBs
- `out_valid`  out  1  drain word valid
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  MAT_MUL_SIZE*DWIDTH  drained row (or column)
- `out_idx`  out  4  index of the drained row/column
- `out_last`  out  1  final drain word
- `busy`  out  1  high in COLLECT or DRAIN
- `collect_done`  out  1  one-cycle pulse after the last drain handshake
- `err_addr`  out  1  sticky: `c_addr` did not match the expected address
- `err_overrun`  out  1  sticky: strobe received outside COLLECT

## Operation
- States: IDLE, COLLECT, DRAIN.
- IDLE -> COLLECT on `start_collect`. On that edge the block:
  - latches base, stride and N;
  - sets N = 16 when `final_mat_mul_size` is 0 or >16;
  - clears `err_addr`, `err_overrun`, the row counter, and `exp_addr` (set to base).
- COLLECT, on each cycle with `c_data_available`:
  - writes `c_data_out` to buffer[row_cnt];
  - sets `err_addr` if `c_addr` != `exp_addr`, but the row is stored regardless;
  - increments `row_cnt` and adds the stride to `exp_addr`, with AWIDTH wrap-around (modulo 2^AWIDTH).
- When row N-1 is written, the state becomes DRAIN on the same edge and the drain index is cleared.
- DRAIN presents buffer[drain_idx]:
  - advances on `out_valid && out_ready`;
  - `out_last` = (drain_idx == N-1);
  - on the last handshake: -> IDLE and `collect_done` is asserted for the following cycle.
- A `c_data_available` in IDLE or DRAIN is discarded and sets `err_overrun`.
- `start_collect` while `busy` is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `out_valid`, `out_last`, `busy`, `collect_done`, `err_addr`, `err_overrun`, `out_idx` = 0;
  - `out_data` = 0.
- Buffer contents are not reset.
- Capture adds no wait states: one row per cycle at full rate.
- The first `out_valid` is asserted the cycle after the edge that writes the last row.
- All outputs are registered.
- While `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` are held stable.
- `out_valid` is never withdrawn without a handshake.
- Back-to-back handshakes drain one word per cycle; the minimum drain is N cycles.
- `busy` goes low in the same cycle `collect_done` is high.
- Reset mid-operation (COLLECT or DRAIN): the block returns to IDLE on the next edge; the partial result is abandoned and no `collect_done` is issued.

## Configuration
- `MATMUL_C_COLLECT_TRANSPOSE_EN` defined: DRAIN emits columns.
  - Word j packs buffer[0..N-1] element j, with row 0 in the LSBs.
  - Rows >= N read as 0.
  - `out_idx` is the column index, and N words are still drained.
- Undefined: DRAIN emits rows unchanged, and no transpose mux is built.

## Structure
- Package `matmul_pkg` holds:
  - `DWIDTH`, `MAT_MUL_SIZE`, and `IDX_W` = $clog2(MAT_MUL_SIZE);
  - the state enum `c_coll_state_t`;
  - the row type `c_row_t` [MAT_MUL_SIZE*DWIDTH-1:0].
- Sub-module `matmul_c_row_buffer`: MAT_MUL_SIZE x row register file with one synchronous write port and one combinational read port, plus full-array visibility when transpose is enabled.
- FSM, counters and error flags stay in the top module.

## Test plan
- Base 0, stride 16, size 16; rows r = {16{r+1}} at `c_addr` 16r, with `out_ready` tied 1.
  - Rows drain in order; the first word is `0x0101…01`; `out_last` on idx 15; `collect_done` once; no errors.
- Same rows with `out_ready` toggling 1/0 every cycle.
  - Data held stable while stalled; 16 handshakes total; order unchanged.
- Row 5 at `c_addr` 0x051 instead of 0x050.
  - `err_addr` = 1 from that cycle until the next `start_collect`; the row is still stored and drained.
- `final_mat_mul_size` = 4, then a stray strobe during DRAIN.
  - 4 words drained; `err_overrun` = 1; the extra row is not stored.
- Assert `reset` after row 7 of 16.
  - Next cycle: IDLE, `busy` = 0, no `out_valid`.
  - A new `start_collect` then completes normally.
- With `MATMUL_C_COLLECT_TRANSPOSE_EN`, element (r,c) = 16r+c.
  - Word 0 holds 0x00, 0x10, …, 0xF0 from the LSBs up.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result-side blocks.
//   DWIDTH         element width in bits
//   MAT_MUL_SIZE   rows/columns of the systolic array
//   IDX_W          width of a row/column index
//   c_coll_state_t collector FSM states
//   c_row_t        one C-matrix row, element 0 in the LSBs
package matmul_pkg;

    localparam int unsigned DWIDTH       = 8;
    localparam int unsigned MAT_MUL_SIZE = 16;
    localparam int unsigned IDX_W        = $clog2(MAT_MUL_SIZE);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDrain   = 2'd2
    } c_coll_state_t;

    typedef logic [MAT_MUL_SIZE*DWIDTH-1:0] c_row_t;

endpackage

// File: rtl/matmul_c_row_buffer.sv
// Row register file for the C collector: ROWS entries of ROW_W bits, no reset.
// Ports:
//   clk        rising-edge clock
//   wr_en      write strobe, wr_data stored at wr_idx on the edge
//   wr_idx     write row index
//   wr_data    write row
//   rd_idx     combinational read row index
//   rd_data    row at rd_idx
//   rows_flat  every row, row r at [r*ROW_W +: ROW_W]; only present when
//              MATMUL_C_COLLECT_TRANSPOSE_EN is defined
module matmul_c_row_buffer
    import matmul_pkg::*;
#(
    parameter int unsigned ROWS  = MAT_MUL_SIZE,
    parameter int unsigned ROW_W = MAT_MUL_SIZE * DWIDTH
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ROW_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [ROW_W-1:0] rd_data
`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
    ,
    output logic [ROWS*ROW_W-1:0] rows_flat
`endif
);

    logic [ROW_W-1:0] mem_q [ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
    always_comb begin
        rows_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            rows_flat[r*ROW_W +: ROW_W] = mem_q[r];
        end
    end
`endif

endmodule

// File: rtl/matmul_c_collector.sv
// Result-side sink for the systolic array. Captures C rows on c_data_available,
// checks their addresses against base + k*stride, buffers up to MAT_MUL_SIZE
// rows, then drains them over a valid/ready stream and pulses collect_done.
// Build option: MATMUL_C_COLLECT_TRANSPOSE_EN drains columns instead of rows.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_collect         arm pulse, honoured only in IDLE
//   address_mat_c         base address of the first row
//   address_stride_c      address increment per row
//   final_mat_mul_size    rows to collect (0 or >MAT_MUL_SIZE means MAT_MUL_SIZE)
//   c_data_available      row strobe from the array
//   c_addr, c_data_out    row address and data from the array
//   out_valid/out_ready   drain handshake
//   out_data, out_idx     drained word and its row/column index
//   out_last              final drain word
//   busy                  collecting or draining
//   collect_done          one-cycle pulse after the last drain handshake
//   err_addr              sticky address mismatch
//   err_overrun           sticky strobe outside COLLECT
module matmul_c_collector
    import matmul_pkg::*;
#(
    parameter int unsigned DWIDTH            = matmul_pkg::DWIDTH,
    parameter int unsigned MAT_MUL_SIZE      = matmul_pkg::MAT_MUL_SIZE,
    parameter int unsigned AWIDTH            = 10,
    parameter int unsigned ADDR_STRIDE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_collect,
    input  logic [AWIDTH-1:0]              address_mat_c,
    input  logic [ADDR_STRIDE_WIDTH-1:0]   address_stride_c,
    input  logic [7:0]                     final_mat_mul_size,
    input  logic                           c_data_available,
    input  logic [AWIDTH-1:0]              c_addr,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] c_data_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic [3:0]                     out_idx,
    output logic                           out_last,
    output logic                           busy,
    output logic                           collect_done,
    output logic                           err_addr,
    output logic                           err_overrun
);

    localparam int unsigned      ROW_W      = MAT_MUL_SIZE * DWIDTH;
    localparam int unsigned      SUM_W      = ADDR_STRIDE_WIDTH + AWIDTH;
    localparam logic [7:0]       MaxSize    = 8'(MAT_MUL_SIZE);
    localparam logic [IDX_W-1:0] LastIdxMax = IDX_W'(MAT_MUL_SIZE - 1);

    c_coll_state_t state_q, state_d;

    logic [IDX_W-1:0]             row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0]             n_last_q, n_last_d;
    logic [IDX_W-1:0]             out_idx_q, out_idx_d;
    logic [AWIDTH-1:0]            exp_addr_q, exp_addr_d;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic                         err_addr_q, err_addr_d;
    logic                         err_overrun_q, err_overrun_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         busy_q, busy_d;
    logic                         collect_done_q, collect_done_d;
    logic [ROW_W-1:0]             out_data_q, out_data_d;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [ROW_W-1:0] rd_data;
    logic [ROW_W-1:0] drain_word;

    logic [SUM_W-1:0]  addr_sum;
    logic [AWIDTH-1:0] exp_addr_nxt;
    logic              unused_addr_sum;

    assign wr_en   = (state_q == StCollect) && c_data_available;
    assign wr_idx  = row_cnt_q;
    assign nxt_idx = out_idx_q + 1'b1;
    // Word loaded into out_data on the coming edge: word 0 when entering DRAIN,
    // otherwise the one after the word currently presented.
    assign rd_idx  = (state_q == StDrain) ? nxt_idx : '0;

    // Address arithmetic wraps modulo 2^AWIDTH; the carry-out is dropped.
    assign addr_sum        = SUM_W'(exp_addr_q) + SUM_W'(stride_q);
    assign exp_addr_nxt    = addr_sum[AWIDTH-1:0];
    assign unused_addr_sum = ^addr_sum[SUM_W-1:AWIDTH];

`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
    logic [MAT_MUL_SIZE*ROW_W-1:0] rows_flat;
`endif

    matmul_c_row_buffer #(
        .ROWS  (MAT_MUL_SIZE),
        .ROW_W (ROW_W)
    ) u_row_buffer (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (c_data_out),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
        ,
        .rows_flat(rows_flat)
`endif
    );

    // The last row is written on the same edge that loads word 0, so the
    // incoming row is forwarded in place of the not-yet-written entry.
`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
    logic [ROW_W-1:0] view_row;
    logic             unused_rd_data;

    assign unused_rd_data = ^rd_data;

    always_comb begin
        drain_word = '0;
        view_row   = '0;
        for (int r = 0; r < MAT_MUL_SIZE; r++) begin
            view_row = rows_flat[r*ROW_W +: ROW_W];
            if (wr_en && (wr_idx == IDX_W'(r))) begin
                view_row = c_data_out;
            end
            // Rows beyond N hold stale data from earlier runs; read them as 0.
            if (IDX_W'(r) <= n_last_q) begin
                drain_word[r*DWIDTH +: DWIDTH] = view_row[rd_idx*DWIDTH +: DWIDTH];
            end
        end
    end
`else
    assign drain_word = (wr_en && (wr_idx == rd_idx)) ? c_data_out : rd_data;
`endif

    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        n_last_d       = n_last_q;
        exp_addr_d     = exp_addr_q;
        stride_d       = stride_q;
        err_addr_d     = err_addr_q;
        err_overrun_d  = err_overrun_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_idx_d      = out_idx_q;
        out_last_d     = out_last_q;
        collect_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_collect) begin
                    state_d       = StCollect;
                    row_cnt_d     = '0;
                    exp_addr_d    = address_mat_c;
                    stride_d      = address_stride_c;
                    err_addr_d    = 1'b0;
                    err_overrun_d = 1'b0;
                    if ((final_mat_mul_size == 8'd0) || (final_mat_mul_size > MaxSize)) begin
                        n_last_d = LastIdxMax;
                    end else begin
                        n_last_d = IDX_W'(final_mat_mul_size - 8'd1);
                    end
                end
                // A stray strobe wins over the clear from a coincident arm.
                if (c_data_available) begin
                    err_overrun_d = 1'b1;
                end
            end

            StCollect: begin
                if (c_data_available) begin
                    if (c_addr != exp_addr_q) begin
                        err_addr_d = 1'b1;
                    end
                    row_cnt_d  = row_cnt_q + 1'b1;
                    exp_addr_d = exp_addr_nxt;
                    if (row_cnt_q == n_last_q) begin
                        state_d     = StDrain;
                        out_valid_d = 1'b1;
                        out_idx_d   = '0;
                        out_last_d  = (n_last_q == '0);
                        out_data_d  = drain_word;
                    end
                end
            end

            StDrain: begin
                if (c_data_available) begin
                    err_overrun_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        state_d        = StIdle;
                        out_valid_d    = 1'b0;
                        out_last_d     = 1'b0;
                        collect_done_d = 1'b1;
                    end else begin
                        out_idx_d  = nxt_idx;
                        out_last_d = (nxt_idx == n_last_q);
                        out_data_d = drain_word;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            row_cnt_q      <= '0;
            n_last_q       <= '0;
            exp_addr_q     <= '0;
            stride_q       <= '0;
            err_addr_q     <= 1'b0;
            err_overrun_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            collect_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_cnt_q      <= row_cnt_d;
            n_last_q       <= n_last_d;
            exp_addr_q     <= exp_addr_d;
            stride_q       <= stride_d;
            err_addr_q     <= err_addr_d;
            err_overrun_q  <= err_overrun_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
            collect_done_q <= collect_done_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = 4'(out_idx_q);
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign collect_done = collect_done_q;
    assign err_addr     = err_addr_q;
    assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_matmul_c_collector.sv
// Self-checking bench for matmul_c_collector. Expected drain words are pushed
// to a scoreboard queue as rows are sent and popped on each handshake.
// Also covers the MATMUL_C_COLLECT_TRANSPOSE_EN build.
module tb_matmul_c_collector;
    import matmul_pkg::*;

    typedef struct packed {
        c_row_t     data;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_collect;
    logic [9:0]  address_mat_c;
    logic [15:0] address_stride_c;
    logic [7:0]  final_mat_mul_size;
    logic        c_data_available;
    logic [9:0]  c_addr;
    c_row_t      c_data_out;
    logic        out_valid;
    logic        out_ready;
    c_row_t      out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        collect_done;
    logic        err_addr;
    logic        err_overrun;

    exp_t   sb[$];
    c_row_t sent [16];
    c_row_t first_word;
    int     first_err_row;
    int     errors = 0;
    int     checks = 0;

    matmul_c_collector dut (
        .clk               (clk),
        .reset             (reset),
        .start_collect     (start_collect),
        .address_mat_c     (address_mat_c),
        .address_stride_c  (address_stride_c),
        .final_mat_mul_size(final_mat_mul_size),
        .c_data_available  (c_data_available),
        .c_addr            (c_addr),
        .c_data_out        (c_data_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_idx           (out_idx),
        .out_last          (out_last),
        .busy              (busy),
        .collect_done      (collect_done),
        .err_addr          (err_addr),
        .err_overrun       (err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pat 0: every element r+1; pat 1: random; pat 2: element c = 16r+c
    function automatic c_row_t make_row(input int pat, input int r);
        c_row_t v;
        v = '0;
        for (int c = 0; c < 16; c++) begin
            if (pat == 0) v[c*8 +: 8] = 8'(r + 1);
            else if (pat == 1) v[c*8 +: 8] = 8'($urandom);
            else v[c*8 +: 8] = 8'(16 * r + c);
        end
        return v;
    endfunction

    task automatic push_expected(input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
            e.data = '0;
            for (int r = 0; r < n; r++) begin
                e.data[r*8 +: 8] = sent[r][j*8 +: 8];
            end
`else
            e.data = sent[j];
`endif
            e.idx  = 4'(j);
            e.last = (j == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic arm(input logic [7:0] size, input logic [9:0] base, input logic [15:0] stride);
        final_mat_mul_size = size;
        address_mat_c      = base;
        address_stride_c   = stride;
        start_collect      = 1'b1;
        tick();
        start_collect      = 1'b0;
    endtask

    task automatic send_rows(input int n, input logic [9:0] base, input logic [15:0] stride,
                             input int pat, input int bad_row);
        logic [9:0] a;
        a = base;
        first_err_row = -1;
        for (int r = 0; r < n; r++) begin
            sent[r]          = make_row(pat, r);
            c_data_available = 1'b1;
            c_data_out       = sent[r];
            c_addr           = (r == bad_row) ? a + 10'd1 : a;
            a                = a + stride[9:0];
            tick();
            if (err_addr && first_err_row < 0) first_err_row = r;
        end
        c_data_available = 1'b0;
        push_expected(n);
    endtask

    task automatic drain(input int nwords, input bit toggle);
        int         hs;
        int         cyc;
        bit         stalled;
        c_row_t     hd;
        logic [3:0] hi;
        logic       hl;
        exp_t       e;
        hs = 0;
        cyc = 0;
        stalled = 0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_first_valid: out_valid=%b, required 1", out_valid);
        end
        while (hs < nwords && cyc < 100) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi || out_last !== hl) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                             out_valid, out_data, out_idx, out_last, hd, hi, hl);
                end
            end
            stalled = 0;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: word idx=%0d drained, required none", out_idx);
                end else begin
                    e = sb.pop_front();
                    if (hs == 0) first_word = out_data;
                    if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                        errors++;
                        $display("FAIL drain_word: data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                                 out_data, out_idx, out_last, e.data, e.idx, e.last);
                    end
                end
                hs++;
            end else if (out_valid) begin
                stalled = 1;
                hd = out_data;
                hi = out_idx;
                hl = out_last;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (hs != nwords) begin
            errors++;
            $display("FAIL drain_count: handshakes=%0d, required %0d", hs, nwords);
        end
        if (!toggle) begin
            checks++;
            if (cyc != nwords) begin
                errors++;
                $display("FAIL drain_rate: cycles=%0d, required %0d", cyc, nwords);
            end
        end
        checks++;
        if (collect_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 0",
                     collect_done, busy, out_valid);
        end
        tick();
        checks++;
        if (collect_done !== 1'b0) begin
            errors++;
            $display("FAIL done_single: collect_done=%b, required 0", collect_done);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d words undrained, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || collect_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b last=%b busy=%b done=%b, required 0 0 0 0",
                     out_valid, out_last, busy, collect_done);
        end
        checks++;
        if (err_addr !== 1'b0 || err_overrun !== 1'b0 || out_idx !== 4'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: err_addr=%b err_overrun=%b idx=%0d data=%h, required 0 0 0 0",
                     err_addr, err_overrun, out_idx, out_data);
        end
        reset = 1'b0;
        tick();
        // Strobe while idle is discarded and flagged.
        c_data_available = 1'b1;
        c_data_out       = make_row(1, 0);
        tick();
        c_data_available = 1'b0;
        checks++;
        if (err_overrun !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_overrun: err_overrun=%b busy=%b valid=%b, required 1 0 0",
                     err_overrun, busy, out_valid);
        end
    endtask

    task automatic test_full_rate();
        c_row_t w0;
        arm(8'd16, 10'd0, 16'd16);
        checks++;
        if (busy !== 1'b1 || err_overrun !== 1'b0 || err_addr !== 1'b0) begin
            errors++;
            $display("FAIL arm_state: busy=%b err_overrun=%b err_addr=%b, required 1 0 0",
                     busy, err_overrun, err_addr);
        end
        send_rows(16, 10'd0, 16'd16, 0, -1);
        drain(16, 1'b0);
        w0 = '0;
        for (int r = 0; r < 16; r++) begin
`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
            w0[r*8 +: 8] = 8'(r + 1);
`else
            w0[r*8 +: 8] = 8'h01;
`endif
        end
        checks++;
        if (first_word !== w0) begin
            errors++;
            $display("FAIL full_first_word: %h, required %h", first_word, w0);
        end
        checks++;
        if (err_addr !== 1'b0 || err_overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_errs: err_addr=%b err_overrun=%b, required 0 0", err_addr, err_overrun);
        end
    endtask

    task automatic test_backpressure();
        arm(8'd16, 10'd0, 16'd16);
        send_rows(16, 10'd0, 16'd16, 0, -1);
        drain(16, 1'b1);
    endtask

    task automatic test_bad_addr();
        arm(8'd16, 10'd0, 16'd16);
        send_rows(16, 10'd0, 16'd16, 1, 5);
        checks++;
        if (first_err_row != 5) begin
            errors++;
            $display("FAIL bad_addr_onset: first flagged row=%0d, required 5", first_err_row);
        end
        drain(16, 1'b0);
        checks++;
        if (err_addr !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr_sticky: err_addr=%b, required 1", err_addr);
        end
    endtask

    task automatic test_size4_overrun();
        arm(8'd4, 10'h100, 16'd1);
        checks++;
        if (err_addr !== 1'b0) begin
            errors++;
            $display("FAIL rearm_clears: err_addr=%b, required 0", err_addr);
        end
        send_rows(4, 10'h100, 16'd1, 1, -1);
        out_ready        = 1'b0;
        c_data_available = 1'b1;
        c_addr           = 10'h104;
        c_data_out       = make_row(1, 9);
        tick();
        c_data_available = 1'b0;
        checks++;
        if (err_overrun !== 1'b1 || out_valid !== 1'b1 || out_idx !== 4'd0) begin
            errors++;
            $display("FAIL drain_overrun: err_overrun=%b valid=%b idx=%0d, required 1 1 0",
                     err_overrun, out_valid, out_idx);
        end
        drain(4, 1'b0);
    endtask

    task automatic test_single_row();
        arm(8'd1, 10'h3FF, 16'd7);
        send_rows(1, 10'h3FF, 16'd7, 1, -1);
        checks++;
        if (out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_last: out_last=%b, required 1", out_last);
        end
        drain(1, 1'b0);
    endtask

    task automatic test_reset_mid();
        arm(8'd16, 10'd0, 16'd16);
        send_rows(8, 10'd0, 16'd16, 1, -1);
        sb.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || collect_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b done=%b, required 0 0 0",
                     busy, out_valid, collect_done);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || collect_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: valid=%b done=%b, required 0 0", out_valid, collect_done);
        end
        // Size 0 means a full 16-row run; addresses wrap past 0x3FF.
        arm(8'd0, 10'h3F0, 16'hFC21);
        send_rows(16, 10'h3F0, 16'hFC21, 1, -1);
        drain(16, 1'b0);
        checks++;
        if (err_addr !== 1'b0) begin
            errors++;
            $display("FAIL wrap_addr: err_addr=%b, required 0", err_addr);
        end
    endtask

    task automatic test_element_map();
        c_row_t w0;
        arm(8'd16, 10'd0, 16'd16);
        send_rows(16, 10'd0, 16'd16, 2, -1);
        drain(16, 1'b0);
        w0 = '0;
        for (int k = 0; k < 16; k++) begin
`ifdef MATMUL_C_COLLECT_TRANSPOSE_EN
            w0[k*8 +: 8] = 8'(16 * k);
`else
            w0[k*8 +: 8] = 8'(k);
`endif
        end
        checks++;
        if (first_word !== w0) begin
            errors++;
            $display("FAIL element_map_word0: %h, required %h", first_word, w0);
        end
    endtask

    initial begin
        reset              = 1'b1;
        start_collect      = 1'b0;
        address_mat_c      = '0;
        address_stride_c   = '0;
        final_mat_mul_size = '0;
        c_data_available   = 1'b0;
        c_addr             = '0;
        c_data_out         = '0;
        out_ready          = 1'b1;
        first_word         = '0;
        first_err_row      = -1;

        test_reset();
        test_full_rate();
        test_backpressure();
        test_bad_addr();
        test_size4_overrun();
        test_single_row();
        test_reset_mid();
        test_element_map();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
